// File: rtl/vrc_irq_wr_dec.sv
// VRC IRQ register write decoder: decodes CPU writes to the IRQ registers and re-issues them as registered one-cycle strobes.
// Optional define VRC_IRQ_RMW_FILT_EN adds a one-entry pending slot that swallows read-modify-write dummy writes.
module vrc_irq_wr_dec #(
    parameter int MODE = 0,
    parameter int A_LO = 4,
    parameter int A_HI = 5
) (
    input  logic        cpu_m2,
    input  logic        map_rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_rw,
    output logic [7:0]  irq_data,
    output logic        irq_rw,
    output logic        ce_latx,
    output logic        ce_latl,
    output logic        ce_lath,
    output logic        ce_ctrl,
    output logic        ce_ackn,
    output logic [7:0]  wr_cnt
);

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_LATX = 3'd1,
        REG_LATL = 3'd2,
        REG_LATH = 3'd3,
        REG_CTRL = 3'd4,
        REG_ACKN = 3'd5
    } reg_e;

    logic [3:0] page;
    logic [1:0] sel;
    reg_e       dec_reg;
    logic       hit;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr;

    always_comb begin
        page    = cpu_addr[15:12];
        sel     = {cpu_addr[A_HI], cpu_addr[A_LO]};
        dec_reg = REG_NONE;
        if (!cpu_rw && cpu_addr[15]) begin
            case (MODE)
                0: begin
                    if (page == 4'hF) begin
                        case (sel)
                            2'd0:    dec_reg = REG_LATL;
                            2'd1:    dec_reg = REG_LATH;
                            2'd2:    dec_reg = REG_CTRL;
                            default: dec_reg = REG_ACKN;
                        endcase
                    end
                end
                1: begin
                    if (page == 4'hF) begin
                        case (sel)
                            2'd0:    dec_reg = REG_LATX;
                            2'd1:    dec_reg = REG_CTRL;
                            2'd2:    dec_reg = REG_ACKN;
                            default: dec_reg = REG_NONE;
                        endcase
                    end
                end
                default: begin
                    // VRC7 decodes only sel[0]; the high select line is a don't-care.
                    if (page == 4'hE) begin
                        case (sel)
                            2'b01, 2'b11: dec_reg = REG_LATX;
                            default:      dec_reg = REG_NONE;
                        endcase
                    end else if (page == 4'hF) begin
                        case (sel)
                            2'b00, 2'b10: dec_reg = REG_CTRL;
                            default:      dec_reg = REG_ACKN;
                        endcase
                    end
                end
            endcase
        end
    end

    assign hit = (dec_reg != REG_NONE);

    function automatic logic [4:0] reg_onehot(input reg_e r);
        case (r)
            REG_LATX: reg_onehot = 5'b00001;
            REG_LATL: reg_onehot = 5'b00010;
            REG_LATH: reg_onehot = 5'b00100;
            REG_CTRL: reg_onehot = 5'b01000;
            REG_ACKN: reg_onehot = 5'b10000;
            default:  reg_onehot = 5'b00000;
        endcase
    endfunction

    reg_e       iss_reg;
    logic [7:0] iss_data;
    logic       iss_vld;

`ifdef VRC_IRQ_RMW_FILT_EN
    reg_e       pend_reg;
    logic [7:0] pend_data;
    logic       pend_vld;

    // A pending write is superseded when the very next cycle rewrites the same register.
    always_comb begin
        iss_vld  = pend_vld && !(hit && (dec_reg == pend_reg));
        iss_reg  = pend_reg;
        iss_data = pend_data;
    end

    always_ff @(negedge cpu_m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            pend_vld  <= 1'b0;
            pend_reg  <= REG_NONE;
            pend_data <= 8'h00;
        end else begin
            pend_vld <= hit;
            pend_reg <= dec_reg;
            if (hit) begin
                pend_data <= cpu_data;
            end
        end
    end
`else
    always_comb begin
        iss_vld  = hit;
        iss_reg  = dec_reg;
        iss_data = cpu_data;
    end
`endif

    logic [4:0] ce_q;

    always_ff @(negedge cpu_m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            ce_q     <= 5'b00000;
            irq_rw   <= 1'b1;
            irq_data <= 8'h00;
            wr_cnt   <= 8'h00;
        end else if (iss_vld) begin
            ce_q     <= reg_onehot(iss_reg);
            irq_rw   <= 1'b0;
            irq_data <= iss_data;
            wr_cnt   <= wr_cnt + 8'd1;
        end else begin
            ce_q   <= 5'b00000;
            irq_rw <= 1'b1;
        end
    end

    assign ce_latx = ce_q[0];
    assign ce_latl = ce_q[1];
    assign ce_lath = ce_q[2];
    assign ce_ctrl = ce_q[3];
    assign ce_ackn = ce_q[4];

endmodule

// File: tb/tb_vrc_irq_wr_dec.sv
// Bench for vrc_irq_wr_dec: three instances (VRC4/VRC6/VRC7 maps) on one shared bus, scored against a table-driven model.
// Build with +define+VRC_IRQ_RMW_FILT_EN to score the dummy-write filter variant.
module tb_vrc_irq_wr_dec;

    localparam int W = 22;  // {ce[4:0] = ackn,ctrl,lath,latl,latx ; rw ; data ; cnt}
`ifdef VRC_IRQ_RMW_FILT_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam logic [W-1:0] RST_W = {5'b00000, 1'b1, 8'h00, 8'h00};

    // clock / reset / bus
    logic        cpu_m2 = 1'b1;
    logic        map_rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw;

    always #5 cpu_m2 = ~cpu_m2;

    logic [4:0] ce0, ce1, ce2;
    logic       rw0, rw1, rw2;
    logic [7:0] dat0, dat1, dat2;
    logic [7:0] cnt0, cnt1, cnt2;

    vrc_irq_wr_dec #(.MODE(0), .A_LO(0), .A_HI(1)) dut0 (
        .cpu_m2(cpu_m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .irq_data(dat0), .irq_rw(rw0), .ce_latx(ce0[0]), .ce_latl(ce0[1]),
        .ce_lath(ce0[2]), .ce_ctrl(ce0[3]), .ce_ackn(ce0[4]), .wr_cnt(cnt0)
    );
    vrc_irq_wr_dec #(.MODE(1), .A_LO(4), .A_HI(5)) dut1 (
        .cpu_m2(cpu_m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .irq_data(dat1), .irq_rw(rw1), .ce_latx(ce1[0]), .ce_latl(ce1[1]),
        .ce_lath(ce1[2]), .ce_ctrl(ce1[3]), .ce_ackn(ce1[4]), .wr_cnt(cnt1)
    );
    vrc_irq_wr_dec #(.MODE(2), .A_LO(4), .A_HI(5)) dut2 (
        .cpu_m2(cpu_m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .irq_data(dat2), .irq_rw(rw2), .ce_latx(ce2[0]), .ce_latl(ce2[1]),
        .ce_lath(ce2[2]), .ce_ctrl(ce2[3]), .ce_ackn(ce2[4]), .wr_cnt(cnt2)
    );

    // scoreboard queues, one per instance
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];
    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         mode_t[3] = '{0, 1, 2};
    int         alo_t[3]  = '{0, 4, 4};
    int         ahi_t[3]  = '{1, 5, 5};
    int         prev_reg[3];
    logic [7:0] prev_data[3];
    logic [7:0] last_data[3];
    logic [7:0] cnt_m[3];

    // register index: 0 latx, 1 latl, 2 lath, 3 ctrl, 4 ackn, -1 no hit
    function automatic int dec(input int mode, input int alo, input int ahi,
                               input logic [15:0] a, input logic rw);
        int page;
        int s;
        int m0[4] = '{1, 2, 3, 4};
        int m1[4] = '{0, 3, 4, -1};
        page = int'(a[15:12]);
        s = 2 * int'(a[ahi]) + int'(a[alo]);
        if (rw || !a[15]) return -1;
        if (mode == 0) return (page == 15) ? m0[s] : -1;
        if (mode == 1) return (page == 15) ? m1[s] : -1;
        if (page == 14) return a[alo] ? 0 : -1;
        if (page == 15) return a[alo] ? 4 : 3;
        return -1;
    endfunction

    task automatic model_reset(input int di);
        prev_reg[di]  = -1;
        prev_data[di] = 8'h00;
        last_data[di] = 8'h00;
        cnt_m[di]     = 8'h00;
    endtask

    task automatic push_exp(input int di, input logic [W-1:0] w);
        case (di)
            0:       exp_q0.push_back(w);
            1:       exp_q1.push_back(w);
            default: exp_q2.push_back(w);
        endcase
    endtask

    // Expected outputs for the cycle after the one whose inputs are given.
    task automatic model_step(input int di, input logic [15:0] a, input logic [7:0] d,
                              input logic rw, input logic rst);
        int         r;
        int         ir;
        logic [7:0] idat;
        logic [4:0] ce;
        logic       orw;
        r = dec(mode_t[di], alo_t[di], ahi_t[di], a, rw);
        if (FILT) begin
            ir = (prev_reg[di] != r) ? prev_reg[di] : -1;
            idat = prev_data[di];
            prev_reg[di]  = r;
            prev_data[di] = d;
        end else begin
            ir = r;
            idat = d;
        end
        if (!rst) begin
            model_reset(di);
            ce = 5'b00000;
            orw = 1'b1;
        end else if (ir >= 0) begin
            ce = 5'b00000;
            ce[ir] = 1'b1;
            orw = 1'b0;
            last_data[di] = idat;
            cnt_m[di] = cnt_m[di] + 8'd1;
        end else begin
            ce = 5'b00000;
            orw = 1'b1;
        end
        push_exp(di, {ce, orw, last_data[di], cnt_m[di]});
    endtask

    // driver: one M2 cycle of bus activity, applied just after the falling edge
    task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic rst);
        @(negedge cpu_m2);
        #1;
        map_rst_n = rst;
        cpu_addr  = a;
        cpu_data  = d;
        cpu_rw    = rw;
        for (int di = 0; di < 3; di++) model_step(di, a, d, rw, rst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(16'h0000, 8'h00, 1'b1, 1'b1);
    endtask

    // asynchronous reset in the middle of the current cycle, held for two more cycles
    task automatic reset_mid();
        @(posedge cpu_m2);
        #2;
        map_rst_n = 1'b0;
        #2;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int di = 0; di < 3; di++) begin
            model_reset(di);
            push_exp(di, RST_W);
        end
        cycle(16'h0000, 8'h00, 1'b1, 1'b0);
        cycle(16'hF000, 8'h99, 1'b0, 1'b0);
        idle(1);
    endtask

    // monitor
    task automatic cmp(input int di, input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s @%0t: got ce=%b rw=%b data=%h cnt=%h, expected ce=%b rw=%b data=%h cnt=%h",
                     di, nm, $time, act[21:17], act[16], act[15:8], act[7:0],
                     exp[21:17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    task automatic pop_cmp(input int di, input logic [W-1:0] act);
        logic [W-1:0] e;
        int sz;
        case (di)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d queue_underflow @%0t: got empty queue, expected an entry", di, $time);
        end else begin
            case (di)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            cmp(di, "strobe", act, e);
        end
        n_tests++;
        if ($countones(act[21:17]) > 1) begin
            n_fail++;
            $display("FAIL dut%0d onehot @%0t: got ce=%b, expected at most one strobe", di, $time, act[21:17]);
        end
    endtask

    initial begin : monitor
        logic last_rst;
        last_rst = 1'b0;
        #2;
        forever begin
            @(posedge cpu_m2 or negedge map_rst_n);
            #1;
            if (!map_rst_n && last_rst) begin
                cmp(0, "reset_drop", {ce0, rw0, dat0, cnt0}, RST_W);
                cmp(1, "reset_drop", {ce1, rw1, dat1, cnt1}, RST_W);
                cmp(2, "reset_drop", {ce2, rw2, dat2, cnt2}, RST_W);
            end else begin
                pop_cmp(0, {ce0, rw0, dat0, cnt0});
                pop_cmp(1, {ce1, rw1, dat1, cnt1});
                pop_cmp(2, {ce2, rw2, dat2, cnt2});
            end
            last_rst = map_rst_n;
        end
    end

    // stimulus
    initial begin : stimulus
        logic [15:0] a;
        logic [15:0] prev_a;
        logic [3:0]  pg;
        map_rst_n = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_data  = 8'h00;
        cpu_rw    = 1'b1;
        for (int di = 0; di < 3; di++) begin
            model_reset(di);
            push_exp(di, RST_W);
        end
        cycle(16'h0000, 8'h00, 1'b1, 1'b0);
        cycle(16'hF000, 8'h42, 1'b0, 1'b0);
        idle(3);

        // VRC7 latch write
        cycle(16'hE010, 8'hA5, 1'b0, 1'b1);
        idle(3);
        // VRC4 register sweep, back to back
        cycle(16'hF000, 8'h03, 1'b0, 1'b1);
        cycle(16'hF001, 8'h0C, 1'b0, 1'b1);
        cycle(16'hF002, 8'h02, 1'b0, 1'b1);
        cycle(16'hF003, 8'h00, 1'b0, 1'b1);
        idle(3);
        // read, unmapped select, wrong page
        cycle(16'hF001, 8'hEE, 1'b1, 1'b1);
        cycle(16'hF030, 8'h55, 1'b0, 1'b1);
        cycle(16'hE000, 8'h66, 1'b0, 1'b1);
        cycle(16'h7010, 8'h77, 1'b0, 1'b1);
        idle(3);
        // read-modify-write style double write
        cycle(16'hF010, 8'h12, 1'b0, 1'b1);
        cycle(16'hF010, 8'h34, 1'b0, 1'b1);
        idle(4);

        // reset while a VRC4 ctrl strobe is high, with further writes in flight
        cycle(16'hF002, 8'h5A, 1'b0, 1'b1);
        cycle(16'hF003, 8'h77, 1'b0, 1'b1);
        if (FILT) cycle(16'hF001, 8'h11, 1'b0, 1'b1);
        reset_mid();
        idle(4);

        // counter wrap
        reset_mid();
        for (int i = 0; i < 256; i++) cycle(16'hF000, 8'(i), 1'b0, 1'b1);
        idle(4);

        // randomized traffic, biased towards IRQ pages and repeated addresses
        prev_a = 16'hF000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = prev_a;
            end else begin
                pg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(14, 15));
                a = {pg, 12'($urandom)};
            end
            prev_a = a;
            cycle(a, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
        end
        idle(4);

        @(posedge cpu_m2);
        @(posedge cpu_m2);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
